// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: FSM states, opcodes,
// mux select encodings and the instruction class vector.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_e;

    localparam logic [5:0] OP_AND  = 6'b100000;
    localparam logic [5:0] OP_NOR  = 6'b100110;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [4:0] ALU_ADD = 5'b00001;

    typedef struct packed {
        logic rclass;
        logic nori;
        logic lw;
        logic sw;
        logic bleu;
        logic jr;
        logic jal;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Maps the 6-bit opcode onto a one-hot instruction class vector.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_AND, OP_NOR, OP_NOT, OP_ROLV, OP_RORV: cls_o.rclass = 1'b1;
            OP_NORI: cls_o.nori    = 1'b1;
            OP_LW:   cls_o.lw      = 1'b1;
            OP_SW:   cls_o.sw      = 1'b1;
            OP_BLEU: cls_o.bleu    = 1'b1;
            OP_JR:   cls_o.jr      = 1'b1;
            OP_JAL:  cls_o.jal     = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer: steps each instruction through fetch/decode/execute/memory/writeback,
// handshakes with shared memory and counts retired instructions.
module multicycle_control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      ins,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             branchEnable,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [4:0]       ALUControl,
    output logic             memWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWriteEnable,
    output logic             link,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    op_class_t        cls;
    logic             unused_ins;

    assign unused_ins = ^ins[25:0];

    op_class_decode u_op_class_decode (
        .opcode_i (ins[31:26]),
        .cls_o    (cls)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP});

    // Everything stays zero while reset is held, so no strobe leaks mid-access.
    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        PCWrite        = 1'b0;
        branchEnable   = 1'b0;
        PCSrc          = PCSRC_ALU;
        ALUSrcA        = 1'b0;
        ALUSrcB        = SRCB_REG;
        ALUControl     = 5'b0;
        memWrite       = 1'b0;
        memToReg       = 1'b0;
        regDst         = 1'b0;
        regWriteEnable = 1'b0;
        link           = 1'b0;
        illegal        = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                FETCH: begin
                    mem_req    = 1'b1;
                    ALUSrcB    = SRCB_FOUR;
                    ALUControl = ALU_ADD;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    ALUSrcB    = SRCB_IMM_SH2;
                    ALUControl = ALU_ADD;
                    if (cls.lw || cls.sw)            state_d = MEMADR;
                    else if (cls.rclass || cls.nori) state_d = EXEC;
                    else if (cls.bleu)               state_d = BRANCH;
                    else if (cls.jr || cls.jal)      state_d = JUMP;
                    else begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                end
                MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = ALU_ADD;
                    state_d    = cls.sw ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) state_d = MEMWB;
                end
                MEMWB: begin
                    regWriteEnable = 1'b1;
                    memToReg       = 1'b1;
                    state_d        = FETCH;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                    if (mem_ready) state_d = FETCH;
                end
                EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = cls.nori ? SRCB_IMM : SRCB_REG;
                    ALUControl = ins[31:27];
                    state_d    = ALUWB;
                end
                ALUWB: begin
                    regWriteEnable = 1'b1;
                    regDst         = cls.rclass;
                    ALUControl     = ins[31:27];
                    state_d        = FETCH;
                end
                BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUControl   = ins[31:27];
                    branchEnable = 1'b1;
                    PCSrc        = PCSRC_ALUOUT;
                    state_d      = FETCH;
                end
                JUMP: begin
                    PCWrite = 1'b1;
                    state_d = FETCH;
                    if (cls.jal) begin
                        PCSrc          = PCSRC_JUMP;
                        regWriteEnable = 1'b1;
                        link           = 1'b1;
                    end else begin
                        PCSrc = PCSRC_RS;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle sequencer for the CPU datapath. It replaces the tied-off PCWrite/IorD/IRWrite/ALUSrcA/ALUSrcB strobes with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It issues one shared-memory request per memory phase and stalls on a req/ready handshake. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- ins  in  32  instruction register output; opcode = ins[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC load
- branchEnable  out  1  conditional PC load (bleu)
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 register rs, 11 jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2
- ALUControl  out  5  ALU operation
- memWrite, memToReg, regDst, regWriteEnable, link  out  1 each  datapath controls; link selects $31 and PC as write target/data
- illegal  out  1  one-cycle pulse, unknown opcode
- instr_count  out  CNT_W  retired-instruction count
- state  out  4  current state, for debug

## Operation
- Opcode classes: and 100000, nor 100110, not 000100, rolv 000000, rorv 000010 (R-class); nori 001110; lw 100011; sw 101011; bleu 010000; jr 001000; jal 000011. Every other opcode is illegal.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ALU_ADD.
  - While mem_ready=0, stay in FETCH.
  - When mem_ready=1, IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ALU_ADD (precomputes the branch target into ALUOut). Next state by class:
  - lw/sw → MEMADR
  - R-class/nori → EXEC
  - bleu → BRANCH
  - jr/jal → JUMP
  - illegal → FETCH, with illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ALU_ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regWriteEnable=1, memToReg=1, regDst=0, then FETCH.
- MEMWR: mem_req=1, IorD=1, memWrite=1. Hold until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=10 for nori (00 otherwise), ALUControl=ins[31:27], then ALUWB.
- ALUWB: regWriteEnable=1, regDst=1 for R-class (0 for nori), ALUControl=ins[31:27], then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=ins[31:27], branchEnable=1, PCSrc=01, then FETCH.
- JUMP: PCWrite=1, then FETCH.
  - jr: PCSrc=10.
  - jal: PCSrc=11, regWriteEnable=1, link=1.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP. Illegal opcodes do not count. The counter wraps from all-ones to 0.

## Timing
- Reset: with reset_n=0 at a clk edge, state←FETCH and instr_count←0. While reset_n=0, all outputs are forced to 0, including mem_req.
- First cycle after release: FETCH, mem_req=1.
- Reset mid-access, including with mem_req high: the next edge returns to FETCH. No write strobe may remain asserted while reset_n=0.
- Outputs are decoded from state and ins, except IRWrite and PCWrite in FETCH, which are gated combinationally by mem_ready.
- mem_req stays high until the cycle in which mem_ready=1; the state advances on that edge. mem_ready is ignored while mem_req=0.
- Cycles per instruction with zero-wait memory (mem_ready=1 same cycle): lw 5, sw 4, ALU ops 4, bleu/jr/jal 3, illegal 2. Each wait cycle adds 1.
- ins is assumed stable from DECODE through the end of the instruction.

## Structure
- Shared package cpu_pkg holds:
  - the state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP
  - the opcode constants
  - the PCSrc and ALUSrcB encodings
  - ALU_ADD
- Sub-module op_class_decode: combinational map from ins[31:26] to a one-hot class (rclass, nori, lw, sw, bleu, jr, jal, illegal).

## Test plan
- Reset then lw (100011), mem_ready always 1 → states FETCH,DECODE,MEMADR,MEMRD,MEMWB; memToReg=1 and regWriteEnable=1 in MEMWB; instr_count=1.
- sw with mem_ready low for 3 cycles in MEMWR → memWrite and mem_req held 4 cycles; IorD=1; returns to FETCH; count increments once.
- and (100000) → EXEC has ALUControl=10000, ALUSrcB=00; ALUWB has regDst=1; 4 cycles total.
- jal then jr → jal: PCSrc=11, link=1, regWriteEnable=1. jr: PCSrc=10, regWriteEnable=0. 3 cycles each.
- Opcode 111111 → illegal pulses for 1 cycle in DECODE; FETCH next; instr_count unchanged.
- reset_n low during MEMWR with mem_req=1 → next edge state=FETCH, all outputs 0, instr_count=0. Preload the counter to all-ones and retire one instruction → 0.
